// File: rtl/mod_divider_if.sv
// Handshake and operand/result bundle for mod_divider.
// The master drives the request and operands, the slave returns results and flags.
interface mod_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend_l;
  logic [WIDTH-1:0] dividend_h;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend_l, dividend_h, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend_l, dividend_h, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/mod_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor -> quotient, remainder.
// Define DIV_RADIX4_EN to retire two quotient bits per cycle (WIDTH/2 iterations).
module mod_divider #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mod_divider_if.slave    bus
);

`ifdef DIV_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam int N  = WIDTH / STEPS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] p_t;
  logic [WIDTH-1:0] s_t;
  logic [WIDTH:0]   pw;
  logic             qb;

  // The stored partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
  always_comb begin
    p_t = p_q;
    s_t = s_q;
    pw  = '0;
    qb  = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      pw = {p_t, s_t[WIDTH-1]};
      if (pw >= {1'b0, div_q}) begin
        pw = pw - {1'b0, div_q};
        qb = 1'b1;
      end else begin
        qb = 1'b0;
      end
      p_t = pw[WIDTH-1:0];
      s_t = {s_t[WIDTH-2:0], qb};
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    s_d     = s_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          div_d = bus.divisor;
          p_d   = bus.dividend_h;
          s_d   = bus.dividend_l;
          cnt_d = '0;
          quo_d = '0;
          rem_d = '0;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (bus.divisor == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            quo_d   = '1;
            rem_d   = bus.dividend_l;
          end else if (bus.dividend_h >= bus.divisor) begin
            state_d = DONE;
            ovf_d   = 1'b1;
            quo_d   = '1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d   = p_t;
        s_d   = s_t;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quo_d   = s_t;
          rem_d   = p_t;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      s_q     <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
